// File: rtl/systolic_matrix_loader_if.sv
// Stream-in / matrix-out bundle between the byte source, the loader and the
// systolic multiplier. slave is the loader side, master the driving side.
interface systolic_matrix_loader_if #(
  parameter int N = 4
);
  logic signed [7:0]                  i_data;
  logic                               i_valid;
  logic                               o_ready;
  logic                               i_clear;
  logic                               i_resultValid;
  logic signed [N-1:0][N-1:0][7:0]    o_a;
  logic signed [N-1:0][N-1:0][7:0]    o_b;
  logic                               o_validInput;
  logic                               o_busy;

  modport slave (
    input  i_data, i_valid, i_clear, i_resultValid,
    output o_ready, o_a, o_b, o_validInput, o_busy
  );

  modport master (
    output i_data, i_valid, i_clear, i_resultValid,
    input  o_ready, o_a, o_b, o_validInput, o_busy
  );
endinterface

// File: rtl/systolic_matrix_loader.sv
// Byte-stream loader for the NxN int8 systolic multiplier.
// Fills A then B in row-major order, launches the multiplier with a single
// input-valid pulse, then holds off the source until the result comes back.
// N is expected in 3..256, the range the multiplier accepts.

// One matrix row: N bytes, written one column at a time, only cleared by reset.
module sml_row #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  we,
  input  logic [CW-1:0]         col,
  input  logic [7:0]            data,
  output logic [N-1:0][7:0]     row_q
);
  logic [N-1:0][7:0] row_d;

  // Overwrite the addressed column on a write, otherwise hold.
  always_comb begin
    row_d = row_q;
    if (we) row_d[col] = data;
  end

  // Row storage.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) row_q <= '0;
    else        row_q <= row_d;
  end
endmodule

module systolic_matrix_loader #(
  parameter int N = 4
) (
  input  logic                       i_clk,
  input  logic                       i_arst,
  systolic_matrix_loader_if.slave    bus
);
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_FIRE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          vin_q, vin_d;

  logic          loading;
  logic          xfer;
  logic [N-1:0]  we_a, we_b;
  logic [N-1:0][N-1:0][7:0] a_mat, b_mat;

  // Ready is a pure state decode; clear suppresses the transfer, not ready.
  assign loading = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign xfer    = loading && bus.i_valid && !bus.i_clear;

  // Next state and row/column stepping; row/col replace k/N and k%N.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        if (bus.i_clear) begin
          state_d = S_LOAD_A;
          row_d   = '0;
          col_d   = '0;
        end else if (bus.i_valid) begin
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) begin
              row_d   = '0;
              state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_FIRE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FIRE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_resultValid) begin
          state_d = S_LOAD_A;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: state_d = S_LOAD_A;
    endcase
    // FIRE lasts exactly one cycle, so the pulse is registered on entry.
    vin_d = (state_d == S_FIRE);
  end

  // Control registers.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= S_LOAD_A;
      row_q   <= '0;
      col_q   <= '0;
      vin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      vin_q   <= vin_d;
    end
  end

  // One row writer per matrix row; the current row decodes the enable.
  for (genvar r = 0; r < N; r++) begin : g_row
    assign we_a[r] = xfer && (state_q == S_LOAD_A) && (row_q == CW'(r));
    assign we_b[r] = xfer && (state_q == S_LOAD_B) && (row_q == CW'(r));

    sml_row #(.N(N), .CW(CW)) u_a (
      .i_clk (i_clk),
      .i_arst(i_arst),
      .we    (we_a[r]),
      .col   (col_q),
      .data  (bus.i_data),
      .row_q (a_mat[r])
    );

    sml_row #(.N(N), .CW(CW)) u_b (
      .i_clk (i_clk),
      .i_arst(i_arst),
      .we    (we_b[r]),
      .col   (col_q),
      .data  (bus.i_data),
      .row_q (b_mat[r])
    );
  end

  assign bus.o_ready      = loading;
  assign bus.o_busy       = (state_q == S_FIRE) || (state_q == S_WAIT);
  assign bus.o_validInput = vin_q;
  assign bus.o_a          = a_mat;
  assign bus.o_b          = b_mat;
endmodule

// File: tb/tb_systolic_matrix_loader.sv
// Directed bench for systolic_matrix_loader at N=4.
module tb_systolic_matrix_loader;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] stim [2*N*N];
  logic [7:0] ea [N][N];
  logic [7:0] eb [N][N];

  systolic_matrix_loader_if #(.N(N)) bus ();

  systolic_matrix_loader #(.N(N)) dut (
    .i_clk (clk),
    .i_arst(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mats(input string tag);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        chk($sformatf("%s_a%0d%0d", tag, r, c), 256'(bus.o_a[r][c]), 256'(ea[r][c]));
        chk($sformatf("%s_b%0d%0d", tag, r, c), 256'(bus.o_b[r][c]), 256'(eb[r][c]));
      end
  endtask

  // Streams stim[0..2N^2-1]; optional random bubbles; launch must follow the last element.
  task automatic load(input bit stall);
    int pulses = 0;
    for (int i = 0; i < 2*N*N; i++) begin
      if (stall)
        for (int s = 0; s < 4 && $urandom_range(0, 1) == 1; s++) begin
          bus.i_valid = 1'b0;
          step();
          if (bus.o_validInput) pulses++;
        end
      bus.i_valid = 1'b1;
      bus.i_data  = stim[i];
      step();
      if (i < 2*N*N - 1 && bus.o_validInput) pulses++;
    end
    bus.i_valid = 1'b0;
    chk("launch_pulse", 256'(bus.o_validInput), 256'(1));
    chk("launch_busy", 256'(bus.o_busy), 256'(1));
    chk("launch_ready", 256'(bus.o_ready), 256'(0));
    chk("early_pulse", 256'(pulses), 256'(0));
    step();
    chk("pulse_end", 256'(bus.o_validInput), 256'(0));
    chk("wait_busy", 256'(bus.o_busy), 256'(1));
    chk("wait_ready", 256'(bus.o_ready), 256'(0));
  endtask

  initial begin
    bus.i_data = '0;
    bus.i_valid = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_resultValid = 1'b0;

    // Reset values while reset is held.
    #2;
    chk("rst_ready", 256'(bus.o_ready), 256'(1));
    chk("rst_busy", 256'(bus.o_busy), 256'(0));
    chk("rst_vin", 256'(bus.o_validInput), 256'(0));
    chk("rst_a", 256'(bus.o_a), 256'(0));
    chk("rst_b", 256'(bus.o_b), 256'(0));
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", 256'(bus.o_ready), 256'(1));

    // Basic load: A = 1..16, B = identity.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ea[r][c] = 8'(N*r + c + 1);
        eb[r][c] = (r == c) ? 8'd1 : 8'd0;
        stim[N*r + c]       = ea[r][c];
        stim[N*N + N*r + c] = eb[r][c];
      end
    load(1'b0);
    chk_mats("basic");

    // Backpressure in WAIT: nothing accepted.
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h7F;
    for (int i = 0; i < 20; i++) step();
    chk("bp_ready", 256'(bus.o_ready), 256'(0));
    chk_mats("bp");

    // Result releases the loader at edge u; next 0x7F lands at A[0][0] on u+1.
    bus.i_resultValid = 1'b1;
    step();
    bus.i_resultValid = 1'b0;
    chk("rv_ready", 256'(bus.o_ready), 256'(1));
    chk("rv_busy", 256'(bus.o_busy), 256'(0));
    chk("rv_a00_held", 256'(bus.o_a[0][0]), 256'(8'd1));
    step();
    ea[0][0] = 8'h7F;
    chk("rv_a00", 256'(bus.o_a[0][0]), 256'(ea[0][0]));
    chk("rv_a01", 256'(bus.o_a[0][1]), 256'(ea[0][1]));

    // Clear after 10 elements; the 0x55 sent with it is dropped.
    for (int i = 1; i < 10; i++) begin
      bus.i_data = 8'(8'h20 + i);
      step();
      ea[i / N][i % N] = 8'(8'h20 + i);
    end
    bus.i_clear = 1'b1;
    bus.i_data  = 8'h55;
    step();
    bus.i_clear = 1'b0;
    chk("clr_ready", 256'(bus.o_ready), 256'(1));
    chk("clr_a22_kept", 256'(bus.o_a[2][2]), 256'(ea[2][2]));
    bus.i_data = 8'h66;
    step();
    bus.i_valid = 1'b0;
    ea[0][0] = 8'h66;
    chk("clr_a00", 256'(bus.o_a[0][0]), 256'(ea[0][0]));
    chk("clr_a21", 256'(bus.o_a[2][1]), 256'(ea[2][1]));
    chk("clr_a22", 256'(bus.o_a[2][2]), 256'(ea[2][2]));

    // Spurious result during load leaves counters alone.
    bus.i_resultValid = 1'b1;
    step();
    bus.i_resultValid = 1'b0;
    chk("spur_ready", 256'(bus.o_ready), 256'(1));
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h77;
    step();
    bus.i_valid = 1'b0;
    ea[0][1] = 8'h77;
    chk("spur_a01", 256'(bus.o_a[0][1]), 256'(ea[0][1]));
    chk("spur_a02", 256'(bus.o_a[0][2]), 256'(ea[0][2]));

    // Restart and reload with random stalls: A = -128..-113, B = 0..15.
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ea[r][c] = 8'(8'h80 + N*r + c);
        eb[r][c] = 8'(N*r + c);
        stim[N*r + c]       = ea[r][c];
        stim[N*N + N*r + c] = eb[r][c];
      end
    load(1'b1);
    chk_mats("stall");

    // Clear during WAIT is ignored.
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h11;
    for (int i = 0; i < 5; i++) step();
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    chk("wclr_busy", 256'(bus.o_busy), 256'(1));
    chk("wclr_ready", 256'(bus.o_ready), 256'(0));
    chk("wclr_a00", 256'(bus.o_a[0][0]), 256'(ea[0][0]));

    // Asynchronous reset mid-WAIT, between clock edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 256'(bus.o_ready), 256'(1));
    chk("arst_busy", 256'(bus.o_busy), 256'(0));
    chk("arst_vin", 256'(bus.o_validInput), 256'(0));
    chk("arst_a", 256'(bus.o_a), 256'(0));
    chk("arst_b", 256'(bus.o_b), 256'(0));
    step();
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_matrix_loader.md
# systolic_matrix_loader

- Upstream feeder for the N×N int8 systolic matrix multiplier.
- Accepts a byte stream over a valid/ready handshake and assembles operand matrices A and B, A first, each in row-major order.
- Presents both matrices in parallel and pulses the multiplier's input-valid for exactly one cycle.
- Then blocks further input until the multiplier reports its result, so a running multiplication is never restarted.

## Interface
Parameters:
- N, 4, matrix dimension; legal range 3..256 (matches multiplier check).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_arst  input  1  asynchronous, active-high reset.
- i_data  input  8  signed int8 stream element.
- i_valid  input  1  i_data valid this cycle.
- o_ready  output  1  loader accepts i_data this cycle.
- i_clear  input  1  synchronous abort: discard the partial load and restart at A[0][0].
- i_resultValid  input  1  result-valid pulse from the multiplier.
- o_a  output  N×N×8  signed; matrix A; o_a[r][c] = row r, column c.
- o_b  output  N×N×8  signed; matrix B, same indexing.
- o_validInput  output  1  one-cycle pulse; drives the multiplier's input-valid.
- o_busy  output  1  high from the launch until the result is seen.

## Operation
- Transfer occurs when i_valid && o_ready are both high at a rising edge.
- Element counter: k, range 0..2N²−1, width $clog2(2N²).
  - k < N²: write o_a[k/N][k%N].
  - Otherwise write o_b[(k−N²)/N][(k−N²)%N].
  - Division and modulo are implemented as separate row/column counters; no divider.
- States:
  - LOAD_A: o_ready=1. Each transfer advances the column; at column N−1 it wraps to 0 and the row increments. The transfer at A[N−1][N−1] moves to LOAD_B with row and column at 0.
  - LOAD_B: o_ready=1, same stepping. The transfer at B[N−1][N−1] moves to FIRE.
  - FIRE: o_ready=0, o_validInput=1, o_busy=1. Unconditionally moves to WAIT next cycle.
  - WAIT: o_ready=0, o_busy=1. When i_resultValid=1, moves to LOAD_A with counters at 0.
- o_a and o_b are written only by transfers. They hold their values through FIRE and WAIT and are never cleared except by i_arst. The next load overwrites them element by element.
- i_clear:
  - In LOAD_A or LOAD_B: go to LOAD_A, counters to 0, no transfer that cycle even if i_valid=1. Matrix contents are retained.
  - In FIRE or WAIT: ignored.
- i_resultValid is ignored in every state except WAIT.
- The state, counters and o_validInput come from registers. o_ready and o_busy are decodes of the state register only, with no combinational path from i_valid, i_data or i_resultValid.

## Timing
- Reset values while i_arst=1: state LOAD_A, counters 0, o_a=0, o_b=0, o_validInput=0, o_busy=0, o_ready=1.
  - o_ready=1 applies during reset and on the first cycle after deassertion.
- Throughput: one element per cycle while i_valid stays high. A full load takes 2N² accepting cycles.
- Launch latency: last B element accepted at edge t. o_validInput is high for cycle t..t+1 only, and o_a/o_b already hold the final B element in that cycle.
- i_resultValid sampled high at edge u while in WAIT: o_ready=1 and o_busy=0 from edge u onward. The earliest next transfer is at edge u+1.
- Back-to-back: a stall (i_valid=0) in the middle of a row leaves the counters unchanged. There are no bubbles beyond those the source inserts.
- i_clear and a transfer in the same cycle: i_clear wins and the element is dropped.

## Test plan
- Reset and basic load (N=4):
  - Stream 1..16 for A, then B = identity (1 at B[i][i], 0 elsewhere), with i_valid held high.
  - Required: o_a[r][c]=4r+c+1 and o_b matches identity.
  - o_validInput pulses once, exactly one cycle after the 32nd transfer.
  - o_ready=0 from that cycle onward.
- Backpressure and WAIT:
  - After launch, hold i_valid=1 with data 0x7F for 20 cycles.
  - Required: no transfers and o_a/o_b unchanged.
  - Pulse i_resultValid; o_ready=1 from that edge, and the next 0x7F lands in o_a[0][0].
- Stalls:
  - Toggle i_valid randomly with 50% duty during a load of −128..−113 into A and 0..15 into B.
  - Required: exact placement of every element, and o_validInput fires only after the 32nd accepted element.
- Clear:
  - Load 10 elements, then assert i_clear together with i_valid and data 0x55.
  - Required: 0x55 is dropped, and the next accepted element goes to o_a[0][0].
  - i_clear asserted during WAIT has no effect.
- Spurious result and mid-operation reset:
  - i_resultValid during LOAD_A/LOAD_B is ignored, with the counters unchanged.
  - Assert i_arst during WAIT: all outputs go to their reset values immediately (asynchronously), and o_ready=1.
